nand_gate_sweep_ctrl: RTL

//   Self-checking sequencer for a 2-input nand_gate instance (ports A, B, Y).
//   On a start pulse, drives all four A/B combinations REPEAT times and lets Y

---
 rtl/nand_seq_pkg.sv | 23 ++
 rtl/nand_sweep_chk.sv | 85 ++++++++
 rtl/nand_gate_sweep_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/nand_seq_pkg.sv
// Shared definitions for the nand gate sweep sequencer: state encoding and
// the golden nand model used by the checker.
package nand_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        DRIVE  = ST_DRIVE,
        SETTLE = ST_SETTLE,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_e;

    function automatic logic nand_ref(input logic a, input logic b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/nand_sweep_chk.sv
// Sample compare against the nand golden model, saturating mismatch counter
// and, when FIRST_FAIL_LOG_EN is defined, a latch of the first failing vector.
module nand_sweep_chk
    import nand_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             sample_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             y_i,
`ifdef FIRST_FAIL_LOG_EN
    input  logic [1:0]       vec_i,
    output logic             fail_valid_o,
    output logic [1:0]       fail_vec_o,
    output logic             fail_y_o,
`endif
    output logic [CNT_W-1:0] err_cnt_o
);

    logic             mismatch;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign mismatch = sample_i && (y_i != nand_ref(a_i, b_i));

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_i) begin
            err_cnt_d = '0;
        end else if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;

`ifdef FIRST_FAIL_LOG_EN
    logic       fail_valid_q, fail_valid_d;
    logic [1:0] fail_vec_q, fail_vec_d;
    logic       fail_y_q, fail_y_d;

    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        fail_y_d     = fail_y_q;
        if (clr_i) begin
            fail_valid_d = 1'b0;
            fail_vec_d   = 2'b00;
            fail_y_d     = 1'b0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_i;
            fail_y_d     = y_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'b00;
            fail_y_q     <= 1'b0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            fail_y_q     <= fail_y_d;
        end
    end

    assign fail_valid_o = fail_valid_q;
    assign fail_vec_o   = fail_vec_q;
    assign fail_y_o     = fail_y_q;
`endif

endmodule

// File: rtl/nand_gate_sweep_ctrl.sv
// Sweep sequencer for a 2-input nand gate: drives A/B through 00,01,10,11
// REPEAT times, checks Y after a settle delay. FIRST_FAIL_LOG_EN adds fail_* ports.
//
//   state  | meaning
//   IDLE   | waiting for start
//   DRIVE  | register A/B from vec, load settle timer
//   SETTLE | count down SETTLE_CYC cycles while Y settles
//   SAMPLE | compare Y, advance vec/rep
//   DONE   | publish pass, pulse done
module nand_gate_sweep_ctrl
    import nand_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int REPEAT     = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             a_o,
    output logic             b_o,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef FIRST_FAIL_LOG_EN
    output logic             fail_valid,
    output logic [1:0]       fail_vec,
    output logic             fail_y,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    state_e           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             a_q, a_d, b_q, b_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic             chk_clr, chk_sample;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        rep_d      = rep_q;
        settle_d   = settle_q;
        a_d        = a_q;
        b_d        = b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        chk_clr    = 1'b0;
        chk_sample = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    chk_clr = 1'b1;
                    pass_d  = 1'b0;
                    vec_d   = 2'b00;
                    rep_d   = '0;
                    busy_d  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE, SETTLE, SAMPLE: begin
                // abort preempts the sample so err_cnt keeps its pre-abort value
                if (abort) begin
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else if (state_q == DRIVE) begin
                    a_d      = vec_q[1];
                    b_d      = vec_q[0];
                    settle_d = SET_W'(SETTLE_CYC - 1);
                    state_d  = SETTLE;
                end else if (state_q == SETTLE) begin
                    if (settle_q == '0) begin
                        state_d = SAMPLE;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end else begin
                    chk_sample = 1'b1;
                    if (vec_q != 2'b11) begin
                        vec_d   = vec_q + 2'b01;
                        state_d = DRIVE;
                    end else if (rep_q != REP_W'(REPEAT - 1)) begin
                        vec_d   = 2'b00;
                        rep_d   = rep_q + 1'b1;
                        state_d = DRIVE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_cnt == '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= 2'b00;
            rep_q    <= '0;
            settle_q <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            rep_q    <= rep_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    nand_sweep_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (chk_clr),
        .sample_i     (chk_sample),
        .a_i          (a_q),
        .b_i          (b_q),
        .y_i          (y_i),
`ifdef FIRST_FAIL_LOG_EN
        .vec_i        (vec_q),
        .fail_valid_o (fail_valid),
        .fail_vec_o   (fail_vec),
        .fail_y_o     (fail_y),
`endif
        .err_cnt_o    (err_cnt)
    );

    assign a_o  = a_q;
    assign b_o  = b_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule
